// File: rtl/platform_manager_pkg.sv
// Shared definitions for the platform manager: default geometry, LFSR constants
// and the walk FSM state encoding.
package platform_manager_pkg;

   localparam int DEF_HOR_W    = 7;
   localparam int DEF_VER_W    = 8;
   localparam int DEF_WID_W    = 6;
   localparam int DEF_SCREEN_W = 100;
   localparam int DEF_SCREEN_H = 150;

   // Fibonacci taps 16,14,13,11 expressed as bits 15,13,12,10 of a left-shifting register
   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } pm_state_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/platform_manager_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when step is high.
module lfsr16
   import platform_manager_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [15:0] state
);

   logic [15:0] state_q, state_d;

   always_comb begin
      state_d = step ? lfsr_next(state_q) : state_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SEED;
      else     state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/platform_manager.sv
// Scrolls and respawns the jump-game platforms one per cycle on each tick,
// answers registered ball-on-platform queries and counts respawns as score.
module platform_manager
   import platform_manager_pkg::*;
#(
   parameter int          NUM_PLAT   = 5,
   parameter int          HOR_W      = DEF_HOR_W,
   parameter int          VER_W      = DEF_VER_W,
   parameter int          WID_W      = DEF_WID_W,
   parameter int          SCREEN_W   = DEF_SCREEN_W,
   parameter int          SCREEN_H   = DEF_SCREEN_H,
   parameter int          SPACING    = 30,
   parameter int          INIT_WIDTH = 20,
   parameter int          MIN_WIDTH  = 8,
   parameter logic [15:0] LFSR_SEED  = DEF_LFSR_SEED
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      tick,
   input  logic [VER_W-1:0]          scroll_amt,
   output logic                      busy,
   output logic                      done,
   output logic [NUM_PLAT*VER_W-1:0] plat_ver,
   output logic [NUM_PLAT*HOR_W-1:0] plat_hor,
   output logic [NUM_PLAT*WID_W-1:0] plat_width,
   input  logic                      query_valid,
   input  logic [VER_W-1:0]          query_ver,
   input  logic [HOR_W-1:0]          query_hor,
   output logic                      hit_valid,
   output logic                      hit,
   output logic [3:0]                hit_idx,
   output logic [15:0]               score
);

   localparam logic [VER_W:0] SCREEN_H_X = (VER_W+1)'(SCREEN_H);

   pm_state_e        state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [VER_W-1:0] amt_q, amt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [15:0]      score_q, score_d;
   logic [VER_W-1:0] ver_q [NUM_PLAT];
   logic [VER_W-1:0] ver_d [NUM_PLAT];
   logic [HOR_W-1:0] hor_q [NUM_PLAT];
   logic [HOR_W-1:0] hor_d [NUM_PLAT];
   logic [WID_W-1:0] wid_q [NUM_PLAT];
   logic [WID_W-1:0] wid_d [NUM_PLAT];
   logic             hit_valid_q, hit_valid_d, hit_q, hit_d;
   logic [3:0]       hit_idx_q, hit_idx_d;

   logic [15:0]      lfsr_state;
   logic             lfsr_step;
   logic [VER_W:0]   sum;
   logic [WID_W-1:0] wnew;
   logic [HOR_W-1:0] cand;
   logic [15:0]      lim;
   logic             match_any;
   logic [3:0]       match_idx;
   logic             unused_lfsr_hi;

   assign unused_lfsr_hi = ^lfsr_state[15:HOR_W+4];

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  (lfsr_step),
      .state (lfsr_state)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      amt_d     = amt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      score_d   = score_q;
      ver_d     = ver_q;
      hor_d     = hor_q;
      wid_d     = wid_q;
      lfsr_step = 1'b0;
      sum       = '0;
      wnew      = '0;
      cand      = '0;
      lim       = '0;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               amt_d   = (scroll_amt > SPACING) ? VER_W'(SPACING) : scroll_amt;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_WALK;
            end
         end
         ST_WALK: begin
            for (int unsigned i = 0; i < NUM_PLAT; i++) begin
               if (idx_q == 4'(i)) begin
                  sum = {1'b0, ver_q[i]} + {1'b0, amt_q};
                  if (sum < SCREEN_H_X) begin
                     ver_d[i] = sum[VER_W-1:0];
                  end else begin
                     // amt <= SPACING keeps sum below 2*SCREEN_H, so one subtraction wraps it
                     ver_d[i] = VER_W'(sum - SCREEN_H_X);
                     wnew     = WID_W'(MIN_WIDTH) + WID_W'(lfsr_state[3:0]);
                     cand     = lfsr_state[HOR_W+3:4];
                     lim      = 16'(SCREEN_W) - 16'(wnew);
                     hor_d[i] = (16'(cand) > lim) ? HOR_W'(lim) : cand;
                     wid_d[i] = wnew;
                     lfsr_step = 1'b1;
                     score_d  = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                  end
               end
            end
            if (idx_q == 4'(NUM_PLAT-1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < NUM_PLAT; i++) begin
         if (!match_any && query_ver == ver_q[i] && query_hor >= hor_q[i] &&
             16'(query_hor) < 16'(hor_q[i]) + 16'(wid_q[i])) begin
            match_any = 1'b1;
            match_idx = 4'(i);
         end
      end
      hit_valid_d = query_valid;
      hit_d       = query_valid ? match_any : hit_q;
      hit_idx_d   = query_valid ? match_idx : hit_idx_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         amt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         score_q     <= '0;
         hit_valid_q <= 1'b0;
         hit_q       <= 1'b0;
         hit_idx_q   <= '0;
         for (int unsigned i = 0; i < NUM_PLAT; i++) begin
            ver_q[i] <= VER_W'(SCREEN_H - 1 - i * SPACING);
            hor_q[i] <= HOR_W'(SCREEN_W / 2 - INIT_WIDTH / 2);
            wid_q[i] <= WID_W'(INIT_WIDTH);
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         amt_q       <= amt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         score_q     <= score_d;
         hit_valid_q <= hit_valid_d;
         hit_q       <= hit_d;
         hit_idx_q   <= hit_idx_d;
         ver_q       <= ver_d;
         hor_q       <= hor_d;
         wid_q       <= wid_d;
      end
   end

   for (genvar g = 0; g < NUM_PLAT; g++) begin : g_pack
      assign plat_ver[g*VER_W +: VER_W]   = ver_q[g];
      assign plat_hor[g*HOR_W +: HOR_W]   = hor_q[g];
      assign plat_width[g*WID_W +: WID_W] = wid_q[g];
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign score     = score_q;
   assign hit_valid = hit_valid_q;
   assign hit       = hit_q;
   assign hit_idx   = hit_idx_q;

endmodule

// File: doc/platform_manager.md
Name: platform_manager

Overview:
- Owns the N scrolling platforms of the jump game; generalises the fixed platform0..3/out_platform wiring into one parametrised block with flattened position buses.
- Per scroll tick, walks all platforms one per cycle, moving them down by a clamped amount and respawning at the top any platform that leaves the bottom, with LFSR-random position and width.
- Answers registered ball-on-platform hit queries for ball_movement and counts passed platforms as the score. Sits between ball_movement (tick/scroll source, hit consumer) and SRAM_256kx16 (renderer).

Parameters:
- NUM_PLAT, 5, number of platforms (2..16).
- HOR_W, 7, horizontal coordinate width.
- VER_W, 8, vertical coordinate width (0 = top row, increasing downward).
- WID_W, 6, platform width field width.
- SCREEN_W, 100, playfield columns.
- SCREEN_H, 150, playfield rows. NUM_PLAT*SPACING must equal SCREEN_H.
- SPACING, 30, vertical distance between platforms.
- INIT_WIDTH, 20, platform width after reset.
- MIN_WIDTH, 8, minimum respawn width.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle scroll request.
- scroll_amt  in  VER_W  rows to scroll, sampled with tick.
- busy  out  1  walk in progress.
- done  out  1  one-cycle pulse when the walk completes.
- plat_ver  out  NUM_PLAT*VER_W  platform i at bits [i*VER_W +: VER_W].
- plat_hor  out  NUM_PLAT*HOR_W  left column, same packing.
- plat_width  out  NUM_PLAT*WID_W  width, same packing.
- query_valid  in  1  hit query strobe.
- query_ver  in  VER_W  ball bottom row.
- query_hor  in  HOR_W  ball column.
- hit_valid  out  1  query answer strobe.
- hit  out  1  ball is on a platform.
- hit_idx  out  4  lowest matching platform index.
- score  out  16  respawn count, saturating at 16'hFFFF.

Behaviour:
- Reset (async, immediate): platform i gets ver = SCREEN_H-1-i*SPACING, hor = SCREEN_W/2-INIT_WIDTH/2, width = INIT_WIDTH. lfsr = LFSR_SEED. score = 0; busy = done = hit_valid = hit = hit_idx = 0. FSM = IDLE. A reset during a walk abandons it with no partial state retained.
- FSM states: IDLE, WALK, DONE.
  - IDLE: on tick, latch amt = min(scroll_amt, SPACING), set idx = 0, busy = 1, go to WALK.
  - WALK: one cycle per platform idx.
    - sum = ver[idx] + amt, computed at VER_W+1 bits.
    - If sum < SCREEN_H: ver[idx] = sum.
    - Else respawn: ver[idx] = sum - SCREEN_H; width = MIN_WIDTH + lfsr[3:0]; cand = lfsr[HOR_W+3:4]; hor = min(cand, SCREEN_W - new width); lfsr steps once (Fibonacci, taps 16,14,13,11); score += 1, saturating.
    - lfsr steps only on a respawn. idx == NUM_PLAT-1 goes to DONE, otherwise idx+1.
  - DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- Latency: tick accepted in cycle 0, done high in cycle NUM_PLAT+1, next tick accepted in cycle NUM_PLAT+2.
- A tick while busy or in DONE is ignored (dropped, not queued).
- scroll_amt = 0 still performs the walk and pulses done; nothing changes.
- Clamping amt to SPACING guarantees at most one wrap per platform per tick.
- Outputs change platform by platform during WALK; consumers must sample on done or while busy = 0.
- Hit query:
  - Registered, 1-cycle latency: hit_valid = query_valid delayed by one cycle.
  - Platform i matches when query_ver == ver[i] and ver[i] ≤ query_hor ≤ hor[i]+width[i]-1 is replaced by: query_ver == ver[i] and hor[i] ≤ query_hor ≤ hor[i]+width[i]-1.
  - hit = any match; hit_idx = lowest matching index, 0 if no match.
  - Queries are evaluated against current registers and are also served while busy.
  - hit and hit_idx hold their values until the next query.

Decomposition:
- Shared package: coordinate widths, SCREEN_W/SCREEN_H, LFSR tap mask and seed, FSM state enum.
- One natural sub-module: lfsr16 (step enable, async reset to seed, 16-bit state output).
- Update datapath, FSM and hit comparator stay in platform_manager.

Test Plan:
- Reset with defaults -> plat_ver = {29,59,89,119,149} for indices 4..0; every hor = 40, width = 20; score = 0, busy = 0.
- tick, scroll_amt = 10 -> done in cycle 6. ver0 = 9 (respawned, width 8..23, hor + width ≤ 100); ver1..4 = 129, 99, 69, 39; score = 1.
- tick, scroll_amt = 200 -> treated as 30: every platform moves 30; platform 0 wraps to 149-150+30 = 29; score = 1; spacing stays 30.
- Second tick asserted in cycle 2 of a walk -> ignored; exactly one done pulse; positions reflect a single scroll.
- query_ver = 119, query_hor = 40 after reset -> next cycle hit_valid = 1, hit = 1, hit_idx = 1. query_hor = 60 -> hit = 0.
- rst asserted mid-walk (cycle 3) -> outputs return to reset values immediately; lfsr = 16'hACE1; no done pulse.
